// File: rtl/adc_acq_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_acq_scheduler_if
//  Purpose  : Conversion handshake (start/done/data) and sample stream
//             (data/valid/ready) of the ADC acquisition scheduler.
//             Signal names are seen from the scheduler side.
//  Revision : 1.0  initial release
// ============================================================================
interface adc_acq_scheduler_if;
  logic       o_conv_start;
  logic       i_conv_done;
  logic [7:0] i_conv_data;
  logic [7:0] o_sample_data;
  logic       o_sample_valid;
  logic       i_sample_ready;

  // Scheduler side
  modport master (
    output o_conv_start, o_sample_data, o_sample_valid,
    input  i_conv_done, i_conv_data, i_sample_ready
  );

  // ADC controller / sample consumer side
  modport slave (
    input  o_conv_start, o_sample_data, o_sample_valid,
    output i_conv_done, i_conv_data, i_sample_ready
  );
endinterface
`default_nettype wire

// File: rtl/adc_acq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : adc_acq_scheduler
//  Purpose  : Decides when ADC0804 conversions start (periodic timer or
//             software one-shot), waits for completion and buffers results
//             in a small FIFO with a valid/ready output.
//  Options  : define ADC_SCHED_TIMEOUT_EN to add the CONVERT watchdog;
//             without it CONVERT waits indefinitely and o_timeout is 0.
//  Revision : 1.0  initial release
// ============================================================================
module adc_acq_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                i_clk_100MHz,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_continuous,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_single,
  input  logic                i_clear_flags,
  output logic                o_busy,
  output logic                o_overflow,
  output logic                o_overrun,
  output logic                o_timeout,
  adc_acq_scheduler_if.master acq_bus
);

  localparam int C_AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_START     = 3'd2,
    S_CONVERT   = 3'd3,
    S_STORE     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] w_period;
  logic [PERIOD_W-1:0] w_period_last;
  logic [PERIOD_W-1:0] r_timer;
  logic                w_mode_on;
  logic                w_tick;
  logic                w_in_flight;
  logic                w_latch;
  logic                w_push;
  logic                w_push_ok;
  logic                w_pop;
  logic                w_full;
  logic                w_wd_expire;
  logic [7:0]          r_hold;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [C_AW-1:0]     r_wr_ptr;
  logic [C_AW-1:0]     r_rd_ptr;
  logic [C_AW:0]       r_count;
  logic                r_overflow;
  logic                r_overrun;

  // Periods below 2 cannot produce a distinct tick cycle, so clamp them.
  assign w_period      = (i_period < PERIOD_W'(2)) ? PERIOD_W'(2) : i_period;
  assign w_period_last = w_period - PERIOD_W'(1);
  assign w_mode_on     = i_enable & i_continuous;
  // >= keeps the timer from running away if the period is shortened mid-count.
  assign w_tick        = w_mode_on && (r_timer >= w_period_last);
  assign w_in_flight   = (r_state == S_START) || (r_state == S_CONVERT) ||
                         (r_state == S_STORE);

  // Free-running sample timer, held at zero while periodic mode is off.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset || !w_mode_on || w_tick) r_timer <= '0;
    else                                 r_timer <= r_timer + PERIOD_W'(1);
  end

  // FSM state register.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && i_continuous)  w_state_nxt = S_WAIT_TICK;
        else if (i_enable && i_single) w_state_nxt = S_START;
      end
      S_WAIT_TICK: begin
        if (!w_mode_on)  w_state_nxt = S_IDLE;
        else if (w_tick) w_state_nxt = S_START;
      end
      S_START: w_state_nxt = S_CONVERT;
      S_CONVERT: begin
        // A done pulse in the watchdog's final cycle still counts.
        if (acq_bus.i_conv_done) begin
          w_latch     = 1'b1;
          w_state_nxt = S_STORE;
        end else if (w_wd_expire) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STORE: begin
        w_push      = 1'b1;
        w_state_nxt = w_mode_on ? S_WAIT_TICK : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding register captures the result in the done cycle.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset)      r_hold <= '0;
    else if (w_latch) r_hold <= acq_bus.i_conv_data;
  end

  assign w_full    = (r_count == (C_AW+1)'(FIFO_DEPTH));
  assign w_pop     = acq_bus.o_sample_valid && acq_bus.i_sample_ready;
  // A full FIFO only accepts when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);

  // Sample FIFO; storage is cleared so the head reads zero after reset.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_hold;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overflow <= (w_push && w_full && !w_pop) || (r_overflow && !i_clear_flags);
      r_overrun  <= (w_tick && w_in_flight)      || (r_overrun  && !i_clear_flags);
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int                C_WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT_CYC - 1);

  logic [C_WD_W-1:0] r_wdog;
  logic              r_timeout;

  assign w_wd_expire = (r_state == S_CONVERT) && (r_wdog == C_WD_LAST) &&
                       !acq_bus.i_conv_done;

  // Watchdog counts cycles spent in CONVERT and restarts outside it.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset || (r_state != S_CONVERT)) r_wdog <= '0;
    else                                   r_wdog <= r_wdog + 1'b1;
  end

  // Sticky timeout flag.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset) r_timeout <= 1'b0;
    else         r_timeout <= w_wd_expire || (r_timeout && !i_clear_flags);
  end

  assign o_timeout = r_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  assign acq_bus.o_conv_start   = (r_state == S_START);
  assign acq_bus.o_sample_valid = (r_count != '0);
  assign acq_bus.o_sample_data  = r_mem[r_rd_ptr];
  assign o_busy                 = w_in_flight;
  assign o_overflow             = r_overflow;
  assign o_overrun              = r_overrun;

endmodule
`default_nettype wire
